btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: number of independent button channels (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a level change (>=1).
REQ-003 The block SHALL have parameter LONG_CYCLES, default 10: cycles after press acceptance at which long-press fires (>=1).
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 3: auto-repeat period after long-press; 0 disables repeat.
REQ-005 The block SHALL have parameter ACTIVE_LOW, default 0: 1 inverts btn at the input, so a pressed button reads 1 internally.
REQ-006 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-007 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port btn, input, WIDTH bits: raw asynchronous button inputs.
REQ-009 Port btn_level, output, WIDTH bits: debounced pressed state per channel.
REQ-010 Port press_pulse, output, WIDTH bits: one-cycle pulse when a press is accepted.
REQ-011 Port release_pulse, output, WIDTH bits: one-cycle pulse when a release is accepted.
REQ-012 Port long_pulse, output, WIDTH bits: one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-013 Port repeat_pulse, output, WIDTH bits: one-cycle pulse for each auto-repeat tick.

Function
REQ-014 Each channel SHALL be fully independent; channels SHALL share only clk and rst.
REQ-015 Each channel SHALL pass btn, after optional inversion, through a 2-FF synchronizer (sync0 -> sync1).
REQ-016 The debounce counter SHALL increment each cycle that sync1 differs from btn_level, and SHALL clear to 0 in any cycle that sync1 equals btn_level.
REQ-017 On the edge where the counter would reach DEBOUNCE_CYCLES, the block SHALL set btn_level to sync1 and clear the counter.
REQ-018 Total latency SHALL be DEBOUNCE_CYCLES+2 clock edges from the first edge sampling a stable new btn value to btn_level and the matching pulse asserting.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-020 press_pulse SHALL assert for exactly one cycle, registered, in the same cycle btn_level rises; release_pulse SHALL behave the same way when btn_level falls.
REQ-021 Each channel SHALL run a hold FSM with states IDLE, HELD and REPEAT: IDLE->HELD on press acceptance; HELD->REPEAT when long_pulse fires; any state->IDLE on release acceptance.
REQ-022 The hold counter SHALL clear to 0 on press acceptance and increment once per cycle in HELD/REPEAT; its width SHALL be sized for max(LONG_CYCLES, REPEAT_CYCLES).
REQ-023 long_pulse SHALL assert once, exactly LONG_CYCLES cycles after press_pulse, provided btn_level is still 1.
REQ-024 In REPEAT with REPEAT_CYCLES>0, repeat_pulse SHALL assert every REPEAT_CYCLES cycles, the first one REPEAT_CYCLES cycles after long_pulse.
REQ-025 In REPEAT with REPEAT_CYCLES=0, the block SHALL remain in REPEAT with no repeat_pulse and a frozen counter.
REQ-026 Release acceptance SHALL take priority over long_pulse and repeat_pulse in the same cycle: release_pulse SHALL be 1 and long_pulse and repeat_pulse SHALL be 0.
REQ-027 Each output bit SHALL have at most one of press_pulse, release_pulse, long_pulse and repeat_pulse high in any cycle.
REQ-028 A release accepted before LONG_CYCLES SHALL produce no long_pulse for that press.

Reset
REQ-029 While rst=0, the block SHALL asynchronously clear all registers, including sync0, sync1, btn_level, the counters, all pulses and FSM=IDLE.
REQ-030 After reset deassertion, a button already held (internal 1) SHALL be accepted as a new press after DEBOUNCE_CYCLES+2 edges.
REQ-031 Reset asserted mid-hold SHALL abort the hold with no release_pulse emitted.

Verification (WIDTH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=0)
REQ-032 The bench SHALL drive btn[0] 0->1 held 8 cycles, then 0, and SHALL check: press_pulse[0] high one cycle at edge 6, btn_level[0]=1; release_pulse[0] one cycle 6 edges after the fall; no long_pulse.
REQ-033 The bench SHALL drive btn[0] with 3-cycle high glitches separated by 1-cycle lows, and SHALL check that all outputs stay 0.
REQ-034 The bench SHALL hold btn[1] for 30 cycles, and SHALL check: long_pulse[1] 10 cycles after press_pulse[1], repeat_pulse[1] at +3, +6, +9 ... after it, and channel 0 silent throughout.
REQ-035 The bench SHALL release btn[1] so that acceptance coincides with a repeat tick, and SHALL check release_pulse[1]=1, repeat_pulse[1]=0 and FSM back in IDLE.
REQ-036 The bench SHALL assert rst=0 mid-hold, then release it with btn still high, and SHALL check: outputs 0 during reset, no release_pulse, and a fresh press_pulse 6 edges after deassertion.
REQ-037 The bench SHALL rerun REQ-032 with ACTIVE_LOW=1 and btn driven 1->0, and SHALL check the identical pulse timing.

Source files
------------

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: 2-FF synchronizer, debounce,
// press/release edge pulses, and a per-channel long-press / auto-repeat FSM.
module btn_conditioner #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 10,
  parameter int REPEAT_CYCLES   = 3,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam bit REP_EN   = (REPEAT_CYCLES > 0);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_e;

  logic [WIDTH-1:0] btn_int_s;

  // Normalise polarity so a pressed button is always 1 internally
  assign btn_int_s = ACTIVE_LOW ? ~btn : btn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic          sync0_r, sync1_r, level_r;
    logic          press_r, release_r, long_r, repeat_r;
    logic [DW-1:0] db_cnt_r;
    logic [HW-1:0] hold_cnt_r;
    hold_state_e   state_r;
    logic          accept_s;

    // A level change is accepted on the edge the counter would reach DEBOUNCE_CYCLES
    assign accept_s = (sync1_r != level_r) && (db_cnt_r == DB_LAST);

    // Synchronizer, debounce counter and hold FSM for this channel
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync0_r    <= 1'b0;
        sync1_r    <= 1'b0;
        level_r    <= 1'b0;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        long_r     <= 1'b0;
        repeat_r   <= 1'b0;
        db_cnt_r   <= '0;
        hold_cnt_r <= '0;
        state_r    <= IDLE;
      end else begin
        sync0_r   <= btn_int_s[i];
        sync1_r   <= sync0_r;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        repeat_r  <= 1'b0;

        if (sync1_r == level_r) begin
          db_cnt_r <= '0;
        end else if (accept_s) begin
          db_cnt_r <= '0;
          level_r  <= sync1_r;
        end else begin
          db_cnt_r <= db_cnt_r + DB_ONE;
        end

        // Release acceptance overrides any long/repeat tick due in the same cycle
        if (accept_s && sync1_r) begin
          press_r    <= 1'b1;
          state_r    <= HELD;
          hold_cnt_r <= '0;
        end else if (accept_s) begin
          release_r  <= 1'b1;
          state_r    <= IDLE;
          hold_cnt_r <= '0;
        end else begin
          case (state_r)
            HELD: begin
              if (hold_cnt_r == LONG_LAST) begin
                long_r     <= 1'b1;
                state_r    <= REPEAT;
                hold_cnt_r <= '0;
              end else begin
                hold_cnt_r <= hold_cnt_r + HOLD_ONE;
              end
            end
            REPEAT: begin
              if (!REP_EN) begin
                hold_cnt_r <= hold_cnt_r;
              end else if (hold_cnt_r == REP_LAST) begin
                repeat_r   <= 1'b1;
                hold_cnt_r <= '0;
              end else begin
                hold_cnt_r <= hold_cnt_r + HOLD_ONE;
              end
            end
            default: begin
              state_r    <= IDLE;
              hold_cnt_r <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[i]     = level_r;
    assign press_pulse[i]   = press_r;
    assign release_pulse[i] = release_r;
    assign long_pulse[i]    = long_r;
    assign repeat_pulse[i]  = repeat_r;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner: an active-high two-channel
// instance and an active-low single-channel instance share clock and reset.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] btn_a;
  logic [1:0] lvl_a, press_a, rel_a, long_a, rep_a;
  logic [0:0] btn_b;
  logic [0:0] lvl_b, press_b, rel_b, long_b, rep_b;

  logic [1:0] acc_press, acc_rel, acc_long, acc_rep, acc_lvl;
  logic       acc_long_b;
  int         errors;
  int         checks;

  btn_conditioner #(
    .WIDTH(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .btn(btn_a), .btn_level(lvl_a), .press_pulse(press_a),
    .release_pulse(rel_a), .long_pulse(long_a), .repeat_pulse(rep_a)
  );

  btn_conditioner #(
    .WIDTH(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .btn(btn_b), .btn_level(lvl_b), .press_pulse(press_b),
    .release_pulse(rel_b), .long_pulse(long_b), .repeat_pulse(rep_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_acc();
    acc_press  = 2'b00;
    acc_rel    = 2'b00;
    acc_long   = 2'b00;
    acc_rep    = 2'b00;
    acc_lvl    = 2'b00;
    acc_long_b = 1'b0;
  endtask

  // Advance one clock edge, settle, and fold outputs into the sticky monitors
  task automatic tick();
    @(posedge clk);
    #1;
    acc_press  = acc_press | press_a;
    acc_rel    = acc_rel | rel_a;
    acc_long   = acc_long | long_a;
    acc_rep    = acc_rep | rep_a;
    acc_lvl    = acc_lvl | lvl_a;
    acc_long_b = acc_long_b | long_b[0];
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    btn_a  = 2'b00;
    btn_b  = 1'b1;
    clr_acc();

    // Reset state
    repeat (3) tick();
    chk("rst_outs_a", {22'd0, lvl_a, press_a, rel_a, long_a, rep_a}, 32'd0);
    chk("rst_outs_b", {27'd0, lvl_b, press_b, rel_b, long_b, rep_b}, 32'd0);
    rst = 1'b1;
    repeat (4) tick();
    chk("idle_outs_a", {22'd0, lvl_a, press_a, rel_a, long_a, rep_a}, 32'd0);

    // Short press on channel 0, plus the same on the active-low instance
    clr_acc();
    btn_a[0] = 1'b1;
    btn_b    = 1'b0;
    repeat (5) tick();
    chk("p_early_a", {30'd0, press_a[0], lvl_a[0]}, 32'd0);
    chk("p_early_b", {30'd0, press_b[0], lvl_b[0]}, 32'd0);
    tick();
    chk("p_edge6_a", {30'd0, press_a, 32'd0} >> 32, 32'd1);
    chk("p_lvl_a", {31'd0, lvl_a[0]}, 32'd1);
    chk("p_edge6_b", {30'd0, press_b[0], lvl_b[0]}, 32'd3);
    tick();
    chk("p_once_a", {30'd0, press_a[0], lvl_a[0]}, 32'd1);
    chk("p_once_b", {30'd0, press_b[0], lvl_b[0]}, 32'd1);
    tick();
    btn_a[0] = 1'b0;
    btn_b    = 1'b1;
    repeat (5) tick();
    chk("r_early_a", {30'd0, rel_a[0], lvl_a[0]}, 32'd1);
    tick();
    chk("r_edge6_a", {30'd0, rel_a, lvl_a}, 32'b0100);
    chk("r_edge6_b", {30'd0, rel_b[0], lvl_b[0]}, 32'd2);
    tick();
    chk("r_once_a", {31'd0, rel_a[0]}, 32'd0);
    chk("short_no_long_a", {30'd0, acc_long}, 32'd0);
    chk("short_no_long_b", {31'd0, acc_long_b}, 32'd0);

    // 3-cycle glitches separated by 1-cycle lows never get accepted
    clr_acc();
    for (int g = 0; g < 4; g++) begin
      btn_a[0] = 1'b1;
      repeat (3) tick();
      btn_a[0] = 1'b0;
      tick();
    end
    repeat (8) tick();
    chk("glitch_quiet", {22'd0, acc_lvl, acc_press, acc_rel, acc_long, acc_rep}, 32'd0);

    // Long hold on channel 1 with auto-repeat
    clr_acc();
    btn_a[1] = 1'b1;
    repeat (6) tick();
    chk("h_press", {30'd0, press_a}, 32'b10);
    repeat (9) tick();
    chk("h_long_early", {30'd0, long_a}, 32'd0);
    tick();
    chk("h_long", {30'd0, long_a}, 32'b10);
    for (int k = 1; k <= 4; k++) begin
      repeat (2) tick();
      chk("h_rep_gap", {30'd0, rep_a}, 32'd0);
      tick();
      chk("h_rep", {30'd0, rep_a}, 32'b10);
    end

    // Release so that acceptance lands on a repeat tick
    btn_a[1] = 1'b0;
    repeat (3) tick();
    chk("rel_rep_prior", {30'd0, rep_a}, 32'b10);
    repeat (3) tick();
    chk("rel_prio", {26'd0, rel_a, rep_a, long_a}, 32'b100000);
    chk("rel_lvl", {30'd0, lvl_a}, 32'd0);
    chk("ch0_silent", {27'd0, acc_lvl[0], acc_press[0], acc_rel[0], acc_long[0], acc_rep[0]}, 32'd0);
    clr_acc();
    repeat (15) tick();
    chk("back_idle", {28'd0, acc_long, acc_rep}, 32'd0);

    // Reset mid-hold, then deassert with the button still held
    clr_acc();
    btn_a[1] = 1'b1;
    repeat (6) tick();
    chk("m_press", {30'd0, press_a}, 32'b10);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("m_rst_async", {22'd0, lvl_a, press_a, rel_a, long_a, rep_a}, 32'd0);
    repeat (3) tick();
    chk("m_rst_hold", {22'd0, lvl_a, press_a, rel_a, long_a, rep_a}, 32'd0);
    chk("m_no_rel", {30'd0, acc_rel}, 32'd0);
    clr_acc();
    rst = 1'b1;
    repeat (5) tick();
    chk("m_press_early", {30'd0, press_a}, 32'd0);
    tick();
    chk("m_press_fresh", {28'd0, press_a, lvl_a}, 32'b1010);
    chk("m_no_rel_after", {30'd0, acc_rel}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
